// File: rtl/vanilla_sb_pkg.sv
// rtl/vanilla_sb_pkg.sv - shared types and default widths for the vanilla ID-stage scoreboard
package vanilla_sb_pkg;

  localparam int sb_reg_addr_width_c = 5;
  localparam int sb_max_out_c        = 15;
  localparam int sb_addr_max_c       = 8;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } sb_state_e;

  // Address fields are sized for the widest supported register file and zero-extended.
  typedef struct packed {
    logic                     reads_rf1;
    logic                     reads_rf2;
    logic                     writes_rf;
    logic                     long_lat;
    logic                     fence;
    logic [sb_addr_max_c-1:0] rs1;
    logic [sb_addr_max_c-1:0] rs2;
    logic [sb_addr_max_c-1:0] rd;
  } sb_issue_s;

endpackage

// File: rtl/vanilla_sb_if.sv
// rtl/vanilla_sb_if.sv - decode/issue/writeback signal bundle between ID stage and scoreboard
interface vanilla_sb_if #(
  parameter int reg_addr_width_p = vanilla_sb_pkg::sb_reg_addr_width_c,
  parameter int max_out_p        = vanilla_sb_pkg::sb_max_out_c
);
  localparam int n_regs_c = 1 << reg_addr_width_p;
  localparam int cnt_w_c  = $clog2(max_out_p + 1);

  logic                        id_v_i;
  logic                        id_ready_o;
  logic                        op_reads_rf1_i;
  logic                        op_reads_rf2_i;
  logic                        op_writes_rf_i;
  logic                        long_lat_i;
  logic                        fence_i;
  logic [reg_addr_width_p-1:0] rs1_i;
  logic [reg_addr_width_p-1:0] rs2_i;
  logic [reg_addr_width_p-1:0] rd_i;
  logic                        ret_v_i;
  logic [reg_addr_width_p-1:0] ret_rd_i;
  logic [n_regs_c-1:0]         pending_o;
  logic [cnt_w_c-1:0]          outstanding_o;
  logic                        err_o;

  modport master (
    output id_v_i, op_reads_rf1_i, op_reads_rf2_i, op_writes_rf_i, long_lat_i, fence_i,
    output rs1_i, rs2_i, rd_i, ret_v_i, ret_rd_i,
    input  id_ready_o, pending_o, outstanding_o, err_o
  );

  modport slave (
    input  id_v_i, op_reads_rf1_i, op_reads_rf2_i, op_writes_rf_i, long_lat_i, fence_i,
    input  rs1_i, rs2_i, rd_i, ret_v_i, ret_rd_i,
    output id_ready_o, pending_o, outstanding_o, err_o
  );
endinterface

// File: rtl/vanilla_sb_counter.sv
// rtl/vanilla_sb_counter.sv - saturating up/down counter of in-flight long-latency writes
module vanilla_sb_counter #(
  parameter int max_p   = 15,
  parameter int width_p = $clog2(max_p + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               inc,
  input  logic               dec,
  output logic [width_p-1:0] count,
  output logic               at_max,
  output logic               is_zero,
  output logic               is_one
);
  localparam logic [width_p-1:0] max_c = width_p'(max_p);
  localparam logic [width_p-1:0] one_c = width_p'(1);

  assign at_max  = (count == max_c);
  assign is_zero = (count == '0);
  assign is_one  = (count == one_c);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && !dec && !at_max) begin
      count <= count + one_c;
    end else if (dec && !inc && !is_zero) begin
      count <= count - one_c;
    end
  end
endmodule

// File: rtl/vanilla_scoreboard.sv
// rtl/vanilla_scoreboard.sv - pending-register scoreboard and issue gate; VANILLA_SB_RETURN_BYPASS_EN enables same-cycle return bypass
module vanilla_scoreboard
  import vanilla_sb_pkg::*;
#(
  parameter int reg_addr_width_p = sb_reg_addr_width_c,
  parameter int max_out_p        = sb_max_out_c
) (
  input logic        clk_i,
  input logic        reset_n_i,
  vanilla_sb_if.slave sb
);
  localparam int n_regs_c = 1 << reg_addr_width_p;
  localparam int cnt_w_c  = $clog2(max_out_p + 1);
  localparam logic [n_regs_c-1:0] one_c = n_regs_c'(1);

  sb_issue_s           iss;
  sb_state_e           state, state_nx;
  logic [n_regs_c-1:0] p, p_eff, ret_vec, clr_vec, set_vec;
  logic [cnt_w_c-1:0]  cnt;
  logic                at_max, is_zero, is_one;
  logic                hit, dec, inc, last_ret, full, busy;
  logic                hazard, budget_stall, fence_stall, run, ready, issue;

  always_comb begin
    iss.reads_rf1 = sb.op_reads_rf1_i;
    iss.reads_rf2 = sb.op_reads_rf2_i;
    iss.writes_rf = sb.op_writes_rf_i;
    iss.long_lat  = sb.long_lat_i;
    iss.fence     = sb.fence_i;
    iss.rs1       = sb_addr_max_c'(sb.rs1_i);
    iss.rs2       = sb_addr_max_c'(sb.rs2_i);
    iss.rd        = sb_addr_max_c'(sb.rd_i);
  end

  function automatic logic lookup(input logic [n_regs_c-1:0] v, input logic [sb_addr_max_c-1:0] a);
    return |(v & (one_c << a));
  endfunction

  // p[0] is held at zero, so a return to x0 never counts as a hit.
  assign ret_vec  = one_c << sb.ret_rd_i;
  assign hit      = sb.ret_v_i & (|(p & ret_vec));
  assign clr_vec  = hit ? ret_vec : '0;
  assign dec      = hit;
  assign last_ret = dec & is_one;

`ifdef VANILLA_SB_RETURN_BYPASS_EN
  assign p_eff = p & ~clr_vec;
  assign full  = at_max & ~dec;
  assign busy  = ~(is_zero | last_ret);
`else
  assign p_eff = p;
  assign full  = at_max;
  assign busy  = ~is_zero;
`endif

  assign hazard       = (iss.reads_rf1 & lookup(p_eff, iss.rs1))
                      | (iss.reads_rf2 & lookup(p_eff, iss.rs2))
                      | (iss.writes_rf & lookup(p_eff, iss.rd));
  assign budget_stall = iss.long_lat & iss.writes_rf & full;
  assign fence_stall  = iss.fence & busy;
  assign ready        = run & ~hazard & ~budget_stall & ~fence_stall;
  assign issue        = sb.id_v_i & ready;
  assign inc          = issue & iss.writes_rf & iss.long_lat & (|iss.rd);
  assign set_vec      = inc ? (one_c << iss.rd) : '0;

  vanilla_sb_counter #(.max_p(max_out_p), .width_p(cnt_w_c)) u_counter (
    .clk     (clk_i),
    .reset_n (reset_n_i),
    .inc     (inc),
    .dec     (dec),
    .count   (cnt),
    .at_max  (at_max),
    .is_zero (is_zero),
    .is_one  (is_one)
  );

  // Set is applied after clear so a same-cycle issue and return to one register leaves it pending.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      p     <= '0;
      sb.err_o <= 1'b0;
    end else begin
      p     <= ((p & ~clr_vec) | set_vec) & ~one_c;
      sb.err_o <= sb.ret_v_i & ~hit;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= RUN;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (sb.id_v_i && fence_stall) state_nx = DRAIN;
      DRAIN:   if (is_zero || last_ret)      state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  always_comb begin
    run = (state == RUN);
  end

  assign sb.id_ready_o    = ready;
  assign sb.pending_o     = p;
  assign sb.outstanding_o = cnt;
endmodule

// File: tb/tb_vanilla_scoreboard.sv
// tb/tb_vanilla_scoreboard.sv - directed and randomized checks of vanilla_scoreboard against a register-array model
module tb_vanilla_scoreboard;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vanilla_sb_if sbi ();
  vanilla_scoreboard dut (.clk_i(clk), .reset_n_i(reset_n), .sb(sbi));

`ifdef VANILLA_SB_RETURN_BYPASS_EN
  localparam bit bypass_c = 1'b1;
`else
  localparam bit bypass_c = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  bit mp[32];
  int mcnt;
  bit mdrain, merr;
  logic last_ready, last_err;
  logic [31:0] last_pend, last_out;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit v, bit r1, bit r2, bit w, bit ll, bit f,
                       int rs1, int rs2, int rd, bit rv, int rrd);
    sbi.id_v_i         = v;
    sbi.op_reads_rf1_i = r1;
    sbi.op_reads_rf2_i = r2;
    sbi.op_writes_rf_i = w;
    sbi.long_lat_i     = ll;
    sbi.fence_i        = f;
    sbi.rs1_i          = 5'(rs1);
    sbi.rs2_i          = 5'(rs2);
    sbi.rd_i           = 5'(rd);
    sbi.ret_v_i        = rv;
    sbi.ret_rd_i       = 5'(rrd);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Register r as seen by the hazard check in the current cycle.
  function automatic bit pend_seen(int r);
    if (r == 0) return 1'b0;
    if (bypass_c && sbi.ret_v_i && int'(sbi.ret_rd_i) == r) return 1'b0;
    return mp[r];
  endfunction

  function automatic int cnt_seen();
    int rrd;
    rrd = int'(sbi.ret_rd_i);
    if (bypass_c && sbi.ret_v_i && rrd != 0 && mp[rrd]) return mcnt - 1;
    return mcnt;
  endfunction

  task automatic step(string tag);
    bit er, vret, nerr, iss;
    int ec, rrd, rd;
    logic [31:0] pv;
    #1;
    ec = cnt_seen();
    er = !mdrain
       && !(sbi.op_reads_rf1_i && pend_seen(int'(sbi.rs1_i)))
       && !(sbi.op_reads_rf2_i && pend_seen(int'(sbi.rs2_i)))
       && !(sbi.op_writes_rf_i && pend_seen(int'(sbi.rd_i)))
       && !(sbi.long_lat_i && sbi.op_writes_rf_i && ec == 15)
       && !(sbi.fence_i && ec != 0);
    for (int i = 0; i < 32; i++) pv[i] = mp[i];
    last_ready = sbi.id_ready_o;
    last_pend  = sbi.pending_o;
    last_out   = 32'(sbi.outstanding_o);
    last_err   = sbi.err_o;
    chk({tag, ".ready"}, 32'(last_ready), 32'(er));
    chk({tag, ".pending"}, last_pend, pv);
    chk({tag, ".outstanding"}, last_out, 32'(mcnt));
    chk({tag, ".err"}, 32'(last_err), 32'(merr));
    rrd  = int'(sbi.ret_rd_i);
    rd   = int'(sbi.rd_i);
    vret = sbi.ret_v_i && rrd != 0 && mp[rrd];
    nerr = sbi.ret_v_i && !vret;
    iss  = sbi.id_v_i && er;
    @(posedge clk);
    if (vret) begin
      mp[rrd] = 1'b0;
      mcnt--;
    end
    if (iss && sbi.op_writes_rf_i && sbi.long_lat_i && rd != 0) begin
      mp[rd] = 1'b1;
      mcnt++;
    end
    if (!mdrain && sbi.id_v_i && sbi.fence_i && ec != 0) mdrain = 1'b1;
    else if (mdrain && mcnt == 0) mdrain = 1'b0;
    merr = nerr;
    @(negedge clk);
  endtask

  task automatic do_reset(string tag);
    idle();
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) mp[i] = 1'b0;
    mcnt = 0;
    mdrain = 1'b0;
    merr = 1'b0;
    chk({tag, ".pending"}, sbi.pending_o, 32'h0);
    chk({tag, ".outstanding"}, 32'(sbi.outstanding_o), 32'h0);
    chk({tag, ".err"}, 32'(sbi.err_o), 32'h0);
    chk({tag, ".ready"}, 32'(sbi.id_ready_o), 32'h1);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    idle();
    @(negedge clk);
    do_reset("reset");

    // RAW on a long-latency load
    drive(1, 0, 0, 1, 1, 0, 0, 0, 5, 0, 0); step("raw.load");
    drive(1, 1, 0, 1, 0, 0, 5, 0, 6, 0, 0); step("raw.stall0");
    chk("raw.stalled", 32'(last_ready), 32'h0);
    step("raw.stall1");
    drive(1, 1, 0, 1, 0, 0, 5, 0, 6, 1, 5); step("raw.ret");
    chk("raw.ret_cycle", 32'(last_ready), 32'(bypass_c));
    drive(1, 1, 0, 1, 0, 0, 5, 0, 6, 0, 0); step("raw.after");
    chk("raw.after_ret", 32'(last_ready), 32'h1);

    // Long-latency write to x0 is not tracked
    drive(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0); step("x0.issue");
    chk("x0.ready", 32'(last_ready), 32'h1);
    idle(); step("x0.after");
    chk("x0.pending", last_pend, 32'h0);
    chk("x0.outstanding", last_out, 32'h0);

    // Fill the outstanding budget
    for (int i = 1; i <= 15; i++) begin
      drive(1, 0, 0, 1, 1, 0, 0, 0, i, 0, 0); step("budget.fill");
    end
    drive(1, 0, 0, 1, 1, 0, 0, 0, 20, 0, 0); step("budget.16th");
    chk("budget.count", last_out, 32'd15);
    chk("budget.16th_stall", 32'(last_ready), 32'h0);
    drive(1, 1, 1, 1, 0, 0, 20, 21, 22, 0, 0); step("budget.add");
    chk("budget.add_issues", 32'(last_ready), 32'h1);
    for (int i = 1; i <= 15; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, i); step("budget.drain");
    end

    // Fence drain
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 0, 1, 1, 0, 0, 0, i, 0, 0); step("fence.fill");
    end
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); step("fence.enter");
    chk("fence.blocked", 32'(last_ready), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, i); step("fence.ret");
      chk("fence.drain_ready", 32'(last_ready), 32'h0);
    end
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); step("fence.issue");
    chk("fence.issues", 32'(last_ready), 32'h1);
    chk("fence.zero", last_out, 32'h0);

    // Return to a non-pending register
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7); step("err.ret");
    idle(); step("err.pulse");
    chk("err.high", 32'(last_err), 32'h1);
    step("err.clear");
    chk("err.low", 32'(last_err), 32'h0);

    // Reset mid-drain, then a stale return
    for (int i = 8; i <= 11; i++) begin
      drive(1, 0, 0, 1, 1, 0, 0, 0, i, 0, 0); step("rst.fill");
    end
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); step("rst.fence");
    step("rst.draining");
    chk("rst.in_drain", 32'(last_ready), 32'h0);
    do_reset("rst.mid");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8); step("rst.stale");
    idle(); step("rst.stale_err");
    chk("rst.stale_pulse", 32'(last_err), 32'h1);

    // Randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 500; n++) begin
      bit v, r1, r2, w, ll, f, rv;
      v  = ($urandom_range(0, 3) != 0);
      f  = ($urandom_range(0, 15) == 0);
      r1 = !f && $urandom_range(0, 1);
      r2 = !f && $urandom_range(0, 1);
      w  = !f && ($urandom_range(0, 3) != 0);
      ll = $urandom_range(0, 1);
      rv = ($urandom_range(0, 9) < 4);
      drive(v, r1, r2, w, ll, f, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), rv, $urandom_range(0, 7));
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
